// File: rtl/or_arb_pkg.sv
// rtl/or_arb_pkg.sv - shared types and constants for the OR-unit arbiter
package or_arb_pkg;

  localparam int DATA_W  = 8;
  localparam int STATS_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } or_arb_state_t;

endpackage

// File: rtl/or_gate_8bit.sv
// rtl/or_gate_8bit.sv - shared 8-bit bitwise OR datapath
import or_arb_pkg::*;

module or_gate_8bit (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] outY
);

  // purely combinational bitwise OR
  always_comb begin
    outY = a | b;
  end

endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, one-hot grant
import or_arb_pkg::*;

module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    reqValid,
  input  logic [ID_W-1:0] rrPtr,
  output logic [N-1:0]    grant,
  output logic            any
);

  localparam logic [ID_W:0] NUM = (ID_W+1)'(N);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  // scan from rrPtr upward, wrapping at N; first valid requester wins
  always_comb begin
    grant = '0;
    any   = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, rrPtr} + (ID_W+1)'(k);
      if (sum >= NUM) begin
        sum = sum - NUM;
      end
      idx = sum[ID_W-1:0];
      if (!any && reqValid[idx]) begin
        grant[idx] = 1'b1;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/or_unit_arbiter.sv
// rtl/or_unit_arbiter.sv - round-robin sequencer for one shared OR unit (option: OR_ARB_STATS_EN)
import or_arb_pkg::*;

module or_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        reqValid,
  output logic [NUM_REQ-1:0]        reqReady,
  input  logic [NUM_REQ*DATA_W-1:0] reqA,
  input  logic [NUM_REQ*DATA_W-1:0] reqB,
  output logic                      respValid,
  input  logic                      respReady,
  output logic [DATA_W-1:0]         respData,
  output logic [ID_W-1:0]           respId,
  output logic [STATS_W-1:0]        statsOps
);

  or_arb_state_t state, next_state;

  logic [ID_W-1:0]    rrPtr;
  logic [NUM_REQ-1:0] grant;
  logic               any;
  logic [ID_W-1:0]    winId;
  logic [DATA_W-1:0]  selA, selB;
  logic [DATA_W-1:0]  opA, opB;
  logic [ID_W-1:0]    opId;
  logic [DATA_W-1:0]  outY;

  rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_pick (
    .reqValid (reqValid),
    .rrPtr    (rrPtr),
    .grant    (grant),
    .any      (any)
  );

  or_gate_8bit u_or (
    .a    (opA),
    .b    (opB),
    .outY (outY)
  );

  // encode the one-hot grant and mux the winner's operands
  always_comb begin
    winId = '0;
    selA  = '0;
    selB  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        winId = winId | ID_W'(i);
        selA  = selA | reqA[i*DATA_W +: DATA_W];
        selB  = selB | reqB[i*DATA_W +: DATA_W];
      end
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // next-state and handshake outputs; ready only from IDLE and never in reset
  always_comb begin
    next_state = state;
    reqReady   = '0;
    respValid  = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) reqReady = grant;
        if (any)  next_state = EXEC;
      end
      EXEC: next_state = RESP;
      RESP: begin
        respValid = 1'b1;
        if (respReady) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // operand capture, result capture and round-robin pointer advance
  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtr    <= '0;
      opA      <= '0;
      opB      <= '0;
      opId     <= '0;
      respData <= '0;
      respId   <= '0;
    end else begin
      if (state == IDLE && any) begin
        opA  <= selA;
        opB  <= selB;
        opId <= winId;
      end
      if (state == EXEC) begin
        respData <= outY;
        respId   <= opId;
      end
      if (state == RESP && respReady) begin
        rrPtr <= (respId == ID_W'(NUM_REQ - 1)) ? '0 : respId + 1'b1;
      end
    end
  end

`ifdef OR_ARB_STATS_EN
  logic [STATS_W-1:0] ops_q;

  // saturating count of completed response handshakes
  always_ff @(posedge clk) begin
    if (rst)                                         ops_q <= '0;
    else if (respValid && respReady && ops_q != '1)  ops_q <= ops_q + 1'b1;
  end

  assign statsOps = ops_q;
`else
  assign statsOps = '0;
`endif

endmodule

// File: tb/tb_or_unit_arbiter.sv
// tb/tb_or_unit_arbiter.sv - directed self-checking bench for or_unit_arbiter
module tb_or_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  reqValid;
  logic [3:0]  reqReady;
  logic [31:0] reqA;
  logic [31:0] reqB;
  logic        respValid;
  logic        respReady;
  logic [7:0]  respData;
  logic [1:0]  respId;
  logic [15:0] statsOps;

  int tests  = 0;
  int failed = 0;
  int ops    = 0;

  or_unit_arbiter #(.NUM_REQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .reqValid  (reqValid),
    .reqReady  (reqReady),
    .reqA      (reqA),
    .reqB      (reqB),
    .respValid (respValid),
    .respReady (respReady),
    .respData  (respData),
    .respId    (respId),
    .statsOps  (statsOps)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_stats(input int n);
`ifdef OR_ARB_STATS_EN
    return 16'(n);
`else
    return 16'(n * 0);
`endif
  endfunction

  // one full accept/exec/resp transaction with respReady held high; starts and ends at a negedge in IDLE
  task automatic do_op(input logic [3:0] v, input logic [3:0] eg, input logic [1:0] eid, input logic [7:0] ed);
    reqValid  = v;
    respReady = 1'b1;
    #1;
    check("grant", 32'(reqReady), 32'(eg));
    @(posedge clk);
    @(negedge clk);
    check("exec_ready", 32'(reqReady), 32'h0);
    check("exec_valid", 32'(respValid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("resp_valid", 32'(respValid), 32'h1);
    check("resp_data", 32'(respData), 32'(ed));
    check("resp_id", 32'(respId), 32'(eid));
    @(posedge clk);
    ops++;
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    reqValid  = 4'hF;
    respReady = 1'b0;
    reqA      = 32'h80A00201;
    reqB      = 32'h08052010;

    // reset with every requester asserting
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(reqReady), 32'h0);
    check("rst_valid", 32'(respValid), 32'h0);
    check("rst_data", 32'(respData), 32'h0);
    check("rst_id", 32'(respId), 32'h0);
    check("rst_stats", 32'(statsOps), 32'h0);
    rst      = 1'b0;
    reqValid = 4'h0;
    ops      = 0;
    @(negedge clk);

    // single request from requester 2: A0|05
    do_op(4'b0100, 4'b0100, 2'd2, 8'hA5);
    reqValid = 4'h0;

    // fresh reset so the pointer starts at 0 for the fairness run
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    ops  = 0;
    reqA = 32'h80400201;
    reqB = 32'h08042010;
    do_op(4'hF, 4'b0001, 2'd0, 8'h11);
    do_op(4'hF, 4'b0010, 2'd1, 8'h22);
    do_op(4'hF, 4'b0100, 2'd2, 8'h44);
    do_op(4'hF, 4'b1000, 2'd3, 8'h88);
    do_op(4'hF, 4'b0001, 2'd0, 8'h11);
    check("stats_fair", 32'(statsOps), 32'(exp_stats(ops)));

    // backpressure: pointer is now 1
    reqValid  = 4'hF;
    respReady = 1'b0;
    #1;
    check("bp_grant", 32'(reqReady), 32'b0010);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(respValid), 32'h1);
      check("bp_data", 32'(respData), 32'h22);
      check("bp_id", 32'(respId), 32'h1);
      check("bp_ready", 32'(reqReady), 32'h0);
      @(posedge clk);
      @(negedge clk);
    end
    respReady = 1'b1;
    @(posedge clk);
    ops++;
    @(negedge clk);
    check("bp_release_valid", 32'(respValid), 32'h0);
    check("bp_next_grant", 32'(reqReady), 32'b0100);

    // requester 2 accepted; pulse reset while in EXEC
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b1;
    reqValid = 4'h0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ops = 0;
    check("rst_exec_stats", 32'(statsOps), 32'h0);
    for (int k = 0; k < 3; k++) begin
      check("rst_exec_no_resp", 32'(respValid), 32'h0);
      @(negedge clk);
    end

    // pointer back to 0: {1,3} grants 1, then 3, then 1
    do_op(4'b1010, 4'b0010, 2'd1, 8'h22);
    do_op(4'b1010, 4'b1000, 2'd3, 8'h88);
    do_op(4'b1010, 4'b0010, 2'd1, 8'h22);
    check("stats_three", 32'(statsOps), 32'(exp_stats(3)));
    check("stats_model", 32'(statsOps), 32'(exp_stats(ops)));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
